// File: rtl/ssd_scan_display.sv
// ssd_scan_display
//   Display stage for the 2-digit BCD countdown stopwatch. It time-multiplexes
//   the tens/units digits onto a 4-digit common-anode seven-segment display.
//   While stop is high, the whole display blinks to show that the countdown
//   has expired.
// Ports
//   clk      system clock
//   rst      asynchronous reset, active-high
//   msb      BCD tens digit
//   lsb      BCD units digit
//   stop     countdown expired
//   ssd_ctl  digit enables, active-low, bit0 = rightmost digit
//   segs     segments {a,b,c,d,e,f,g,dp}, active-low
module ssd_scan_display #(
    parameter int unsigned SCAN_DIV_BITS  = 17,
    parameter int unsigned BLINK_DIV_BITS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] msb,
    input  logic [3:0] lsb,
    input  logic       stop,
    output logic [3:0] ssd_ctl,
    output logic [7:0] segs
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_EXPIRED = 1'b1;

    logic [SCAN_DIV_BITS-1:0]  scan_q, scan_d;
    logic [BLINK_DIV_BITS-1:0] blink_q, blink_d;
    logic [0:0]                state_q, state_d;
    logic [3:0]                ctl_q, ctl_d;
    logic [7:0]                segs_q, segs_d;

    logic [1:0] idx;
    logic [3:0] digit;
    logic       active;
    logic       lit;

    function automatic logic [7:0] decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFD;
        endcase
        return s;
    endfunction

    assign idx    = scan_q[SCAN_DIV_BITS-1 -: 2];
    assign scan_d = scan_q + SCAN_DIV_BITS'(1);

    always_comb begin
        state_d = state_q;
        blink_d = '0;
        case (state_q)
            ST_RUN: begin
                if (stop) state_d = ST_EXPIRED;
            end
            default: begin
                if (stop) blink_d = blink_q + BLINK_DIV_BITS'(1);
                else      state_d = ST_RUN;
            end
        endcase
    end

    // Blink phase taken from the next count so that exactly 2^(N-1) lit
    // cycles follow entry into EXPIRED, and dropping stop lights the display
    // on that same edge.
    assign lit = ~blink_d[BLINK_DIV_BITS-1];

    always_comb begin
        digit  = lsb;
        active = 1'b0;
        case (idx)
            2'd0: begin digit = lsb; active = 1'b1; end
            2'd1: begin digit = msb; active = 1'b1; end
            default: begin digit = lsb; active = 1'b0; end
        endcase
        if (active && lit) begin
            ctl_d  = ~(4'b0001 << idx);
            segs_d = decode(digit);
        end else begin
            ctl_d  = '1;
            segs_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= '0;
            blink_q <= '0;
            state_q <= ST_RUN;
            ctl_q   <= '1;
            segs_q  <= '1;
        end else begin
            scan_q  <= scan_d;
            blink_q <= blink_d;
            state_q <= state_d;
            ctl_q   <= ctl_d;
            segs_q  <= segs_d;
        end
    end

    assign ssd_ctl = ctl_q;
    assign segs    = segs_q;

endmodule
